// File: rtl/word_finder.sv
// ---------------------------------------------------------------------------
// word_finder : Forth dictionary search engine.
//
// Measures the null-terminated token in the terminal input buffer (TIB).
// Then it walks the linked word list, newest entry first, and reports the
// first entry whose name equals the token. The block only reads memory; its
// write strobe is tied low.
//
// Dictionary entry at LFA:
//   LFA+0/+1 : link, 16-bit little-endian (16'hFFFF terminates the list)
//   LFA+2    : name length n
//   LFA+3..  : name bytes
//   PFA      = LFA+3+n
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   en            search enable; a start is sampled when en rises in IDLE
//   aw            CONTEXT (newest LFA) while en=0, TIB address at the start
//   vw            memory read data (one cycle after the address)
//   bsy           search in progress
//   hit           match found (valid once bsy falls)
//   st            FSM state (debug)
//   ao0           dictionary pointer; matched LFA after a hit
//   ao1           TIB pointer during a search; matched PFA after a hit
//   mb_addr       memory read address
//   mb_we         memory write enable (always 0)
//   mb_wdata      memory write data (unused, 0)
//
// Optional build macro FINDER_NOCASE_EN: letters a..z are folded to A..Z on
// both sides before the character comparison.
// ---------------------------------------------------------------------------
module word_finder #(
    parameter int ASZ = 17,
    parameter int DSZ = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [ASZ-1:0] aw,
    input  logic [DSZ-1:0] vw,
    output logic           bsy,
    output logic           hit,
    output logic [2:0]     st,
    output logic [ASZ-1:0] ao0,
    output logic [ASZ-1:0] ao1,
    output logic [ASZ-1:0] mb_addr,
    output logic           mb_we,
    output logic [DSZ-1:0] mb_wdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TLEN = 3'd1,
        S_LNKL = 3'd2,
        S_LNKH = 3'd3,
        S_LEN  = 3'd4,
        S_CHRD = 3'd5,
        S_CHRT = 3'd6,
        S_DONE = 3'd7
    } state_t;

    localparam logic [15:0] LINK_END = 16'hFFFF;

    state_t         state, state_n;
    logic [ASZ-1:0] ctx, ctx_n;
    logic [ASZ-1:0] tib, tib_n;
    logic [7:0]     tlen, tlen_n;
    logic [7:0]     idx, idx_n;
    logic [15:0]    link, link_n;
    logic [DSZ-1:0] held, held_n;
    logic           hit_n, bsy_n;
    logic [ASZ-1:0] ao0_n, ao1_n;
    logic           chr_eq;

    function automatic logic [ASZ-1:0] ext8(input logic [7:0] v);
        return {{(ASZ-8){1'b0}}, v};
    endfunction

    function automatic logic [ASZ-1:0] ext16(input logic [15:0] v);
        return {{(ASZ-16){1'b0}}, v};
    endfunction

`ifdef FINDER_NOCASE_EN
    function automatic logic [DSZ-1:0] to_upper(input logic [DSZ-1:0] b);
        if (b >= 8'h61 && b <= 8'h7A) begin
            return b & 8'hDF;
        end else begin
            return b;
        end
    endfunction

    // Case-folded character comparison.
    always_comb begin
        chr_eq = (to_upper(held) == to_upper(vw));
    end
`else
    // Exact byte comparison.
    always_comb begin
        chr_eq = (held == vw);
    end
`endif

    // Next-state and next-register computation. In every state vw already
    // holds the byte for that state's address, because the address mux below
    // presents the address one cycle earlier from the next-state values.
    always_comb begin
        state_n = state;
        ctx_n   = ctx;
        tib_n   = tib;
        tlen_n  = tlen;
        idx_n   = idx;
        link_n  = link;
        held_n  = held;
        hit_n   = hit;
        ao0_n   = ao0;
        ao1_n   = ao1;

        case (state)
            S_IDLE: begin
                if (en) begin
                    tib_n   = aw;
                    tlen_n  = 8'd0;
                    hit_n   = 1'b0;
                    ao1_n   = aw;
                    state_n = S_TLEN;
                end else begin
                    ctx_n   = aw;
                end
            end
            S_TLEN: begin
                // Length saturates at 255: the scan stops there.
                if (vw == 8'd0 || tlen == 8'hFF) begin
                    ao0_n = ctx;
                    if (ctx == ext16(LINK_END)) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_LNKL;
                    end
                end else begin
                    tlen_n = tlen + 8'd1;
                    ao1_n  = tib + ext8(tlen + 8'd1);
                end
            end
            S_LNKL: begin
                link_n[7:0] = vw;
                state_n     = S_LNKH;
            end
            S_LNKH: begin
                link_n[15:8] = vw;
                state_n      = S_LEN;
            end
            S_LEN: begin
                if (vw != tlen) begin
                    ao0_n = ext16(link);
                    if (link == LINK_END) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_LNKL;
                    end
                end else if (vw == 8'd0) begin
                    hit_n   = 1'b1;
                    ao1_n   = ao0 + ext8(8'd3);
                    state_n = S_DONE;
                end else begin
                    idx_n   = 8'd0;
                    state_n = S_CHRD;
                end
            end
            S_CHRD: begin
                held_n  = vw;
                ao1_n   = tib + ext8(idx);
                state_n = S_CHRT;
            end
            S_CHRT: begin
                if (!chr_eq) begin
                    ao0_n = ext16(link);
                    if (link == LINK_END) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_LNKL;
                    end
                end else if (idx == tlen - 8'd1) begin
                    hit_n   = 1'b1;
                    ao1_n   = ao0 + ext8(8'd3) + ext8(tlen);
                    state_n = S_DONE;
                end else begin
                    idx_n   = idx + 8'd1;
                    state_n = S_CHRD;
                end
            end
            S_DONE: begin
                if (!en) begin
                    state_n = S_IDLE;
                end else begin
                    state_n = S_DONE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Dropping en during an active search aborts it.
        if (!en && state != S_IDLE && state != S_DONE) begin
            state_n = S_IDLE;
            hit_n   = 1'b0;
        end else begin
            state_n = state_n;
        end

        bsy_n = (state_n != S_IDLE) && (state_n != S_DONE);
    end

    // Read-address mux: the address the entered state expects on vw.
    always_comb begin
        case (state_n)
            S_TLEN:  mb_addr = tib_n + ext8(tlen_n);
            S_LNKL:  mb_addr = ao0_n;
            S_LNKH:  mb_addr = ao0_n + ext8(8'd1);
            S_LEN:   mb_addr = ao0_n + ext8(8'd2);
            S_CHRD:  mb_addr = ao0_n + ext8(8'd3) + ext8(idx_n);
            S_CHRT:  mb_addr = tib_n + ext8(idx_n);
            default: mb_addr = ao0_n;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ctx   <= {ASZ{1'b0}};
            tib   <= {ASZ{1'b0}};
            tlen  <= 8'd0;
            idx   <= 8'd0;
            link  <= 16'd0;
            held  <= {DSZ{1'b0}};
            hit   <= 1'b0;
            bsy   <= 1'b0;
            ao0   <= {ASZ{1'b0}};
            ao1   <= {ASZ{1'b0}};
        end else begin
            state <= state_n;
            ctx   <= ctx_n;
            tib   <= tib_n;
            tlen  <= tlen_n;
            idx   <= idx_n;
            link  <= link_n;
            held  <= held_n;
            hit   <= hit_n;
            bsy   <= bsy_n;
            ao0   <= ao0_n;
            ao1   <= ao1_n;
        end
    end

    assign st       = state;
    assign mb_we    = 1'b0;
    assign mb_wdata = {DSZ{1'b0}};

endmodule

// File: tb/tb_word_finder.sv
// ---------------------------------------------------------------------------
// tb_word_finder : self-checking bench for word_finder.
// Directed dictionary scenarios plus randomized dictionaries/tokens compared
// against a behavioural search model working directly on the memory array.
// ---------------------------------------------------------------------------
module tb_word_finder;

    localparam int ASZ = 17;
    localparam int DSZ = 8;
    localparam logic [16:0] END_PTR = 17'h0FFFF;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [ASZ-1:0]  aw;
    logic [DSZ-1:0]  vw;
    logic            bsy;
    logic            hit;
    logic [2:0]      st;
    logic [ASZ-1:0]  ao0;
    logic [ASZ-1:0]  ao1;
    logic [ASZ-1:0]  mb_addr;
    logic            mb_we;
    logic [DSZ-1:0]  mb_wdata;

    logic [7:0] mem [0:131071];
    int errors = 0;
    int checks = 0;
    int chrd_cycles = 0;

    word_finder #(.ASZ(ASZ), .DSZ(DSZ)) dut (
        .clk(clk), .rst(rst), .en(en), .aw(aw), .vw(vw),
        .bsy(bsy), .hit(hit), .st(st), .ao0(ao0), .ao1(ao1),
        .mb_addr(mb_addr), .mb_we(mb_we), .mb_wdata(mb_wdata)
    );

    always #5 clk = ~clk;

    // Single-port memory with one cycle of read latency.
    always @(posedge clk) vw <= mem[mb_addr];

    // Count cycles spent in the character-read state.
    always @(posedge clk) if (st == 3'd5) chrd_cycles <= chrd_cycles + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef FINDER_NOCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    // Reference search: measure the token, then follow links through the array.
    function automatic void model(input logic [16:0] ctx, input logic [16:0] tibp,
                                  output logic mhit, output logic [16:0] mlfa,
                                  output logic [16:0] mpfa);
        int tl;
        int n;
        logic eq;
        logic [16:0] p;
        tl = 0;
        while (tl < 255 && mem[tibp + 17'(tl)] != 8'd0) tl++;
        mhit = 1'b0;
        mlfa = END_PTR;
        mpfa = 17'd0;
        p = ctx;
        for (int g = 0; g < 200 && p != END_PTR; g++) begin
            n = int'(mem[p + 17'd2]);
            if (n == tl) begin
                eq = 1'b1;
                for (int k = 0; k < n; k++)
                    if (fold(mem[p + 17'd3 + 17'(k)]) != fold(mem[tibp + 17'(k)])) eq = 1'b0;
                if (eq) begin
                    mhit = 1'b1;
                    mlfa = p;
                    mpfa = p + 17'd3 + 17'(n);
                    return;
                end
            end
            p = {1'b0, mem[p + 17'd1], mem[p]};
        end
    endfunction

    task automatic put_word(input logic [16:0] lfa, input logic [15:0] lnk, input string name);
        mem[lfa]        = lnk[7:0];
        mem[lfa + 17'd1] = lnk[15:8];
        mem[lfa + 17'd2] = 8'(name.len());
        for (int i = 0; i < name.len(); i++) mem[lfa + 17'd3 + 17'(i)] = name[i];
        mem[lfa + 17'd3 + 17'(name.len())] = 8'hBE;
        mem[lfa + 17'd4 + 17'(name.len())] = 8'hEF;
    endtask

    task automatic put_tib(input logic [16:0] a, input string s);
        for (int i = 0; i < s.len(); i++) mem[a + 17'(i)] = s[i];
        mem[a + 17'(s.len())] = 8'd0;
    endtask

    task automatic start_search(input logic [16:0] ctx, input logic [16:0] tibp);
        @(negedge clk); en = 1'b0; aw = ctx;
        @(negedge clk);
        @(negedge clk); en = 1'b1; aw = tibp;
        @(negedge clk);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (bsy && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check_val("bsy_done", {31'd0, bsy}, 32'd0);
    endtask

    task automatic search_expect(input string tag, input logic [16:0] ctx, input logic [16:0] tibp,
                                 input logic eh, input logic [16:0] e0, input logic [16:0] e1,
                                 output int cyc);
        start_search(ctx, tibp);
        wait_done(cyc);
        check_val({tag, "_hit"}, {31'd0, hit}, {31'd0, eh});
        check_val({tag, "_ao0"}, {15'd0, ao0}, {15'd0, e0});
        if (eh) check_val({tag, "_ao1"}, {15'd0, ao1}, {15'd0, e1});
        check_val({tag, "_st"}, {29'd0, st}, 32'd7);
    endtask

    int cyc;
    int c0;
    int nw;
    int ln;
    logic mh;
    logic [16:0] ml, mp, lfa, prev, ctx;
    logic [7:0] wn [6][8];
    int wl [6];

    initial begin
        rst = 1'b1; en = 1'b0; aw = 17'd0;
        for (int a = 0; a < 131072; a++) mem[a] = 8'd0;
        put_word(17'h10, 16'hFFFF, "abcd");
        put_word(17'h19, 16'h0010, "efgh");
        put_word(17'h22, 16'h0019, "ijkl");
        put_word(17'h37, 16'h0022, "mnop");
        #12;
        check_val("rst_bsy", {31'd0, bsy}, 32'd0);
        check_val("rst_hit", {31'd0, hit}, 32'd0);
        check_val("rst_st", {29'd0, st}, 32'd0);
        check_val("rst_ao0", {15'd0, ao0}, 32'd0);
        check_val("rst_ao1", {15'd0, ao1}, 32'd0);
        check_val("rst_we", {31'd0, mb_we}, 32'd0);
        @(negedge clk); rst = 1'b0;

        put_tib(17'h0, "abcd");
        search_expect("abcd", 17'h37, 17'h0, 1'b1, 17'h10, 17'h17, cyc);
        check_val("abcd_within60", {31'd0, cyc <= 60}, 32'd1);

        put_tib(17'h0, "mnop");
        search_expect("mnop", 17'h37, 17'h0, 1'b1, 17'h37, 17'h3E, cyc);

        put_tib(17'h0, "abce");
        search_expect("abce", 17'h37, 17'h0, 1'b0, END_PTR, 17'h0, cyc);
        check_val("abce_bsy", {31'd0, bsy}, 32'd0);

        c0 = chrd_cycles;
        put_tib(17'h0, "abc");
        search_expect("abc", 17'h37, 17'h0, 1'b0, END_PTR, 17'h0, cyc);
        put_tib(17'h0, "abcde");
        search_expect("abcde", 17'h37, 17'h0, 1'b0, END_PTR, 17'h0, cyc);
        check_val("no_chrd", chrd_cycles - c0, 32'd0);

        put_tib(17'h0, "EFGH");
`ifdef FINDER_NOCASE_EN
        search_expect("nocase", 17'h37, 17'h0, 1'b1, 17'h19, 17'h20, cyc);
`else
        search_expect("exact", 17'h37, 17'h0, 1'b0, END_PTR, 17'h0, cyc);
`endif

        // Empty list: CONTEXT already at the end marker.
        put_tib(17'h0, "abcd");
        search_expect("empty", END_PTR, 17'h0, 1'b0, END_PTR, 17'h0, cyc);

        // Long token saturates at 255 bytes and still terminates.
        for (int i = 0; i < 300; i++) mem[17'h1000 + 17'(i)] = 8'h78;
        search_expect("long", 17'h37, 17'h1000, 1'b0, END_PTR, 17'h0, cyc);

        // Abort by dropping en in the character compare state.
        start_search(17'h37, 17'h0);
        cyc = 0;
        while (st != 3'd6 && cyc < 200) begin @(negedge clk); cyc++; end
        check_val("abort_reach_chrt", {29'd0, st}, 32'd6);
        en = 1'b0;
        @(negedge clk);
        check_val("abort_st", {29'd0, st}, 32'd0);
        check_val("abort_bsy", {31'd0, bsy}, 32'd0);
        check_val("abort_hit", {31'd0, hit}, 32'd0);
        search_expect("after_abort", 17'h37, 17'h0, 1'b1, 17'h10, 17'h17, cyc);

        // Reset in the middle of a search.
        start_search(17'h37, 17'h0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("mid_rst_st", {29'd0, st}, 32'd0);
        check_val("mid_rst_bsy", {31'd0, bsy}, 32'd0);
        check_val("mid_rst_hit", {31'd0, hit}, 32'd0);
        check_val("mid_rst_ao0", {15'd0, ao0}, 32'd0);
        en = 1'b0;
        @(negedge clk); rst = 1'b0;
        search_expect("after_rst", 17'h37, 17'h0, 1'b1, 17'h10, 17'h17, cyc);

        // Randomized dictionaries against the reference model.
        for (int r = 0; r < 40; r++) begin
            for (int a = 17'h100; a < 17'h200; a++) mem[a] = 8'd0;
            for (int a = 17'h40; a < 17'h50; a++) mem[a] = 8'd0;
            nw = 1 + int'($urandom_range(0, 5));
            lfa = 17'h100 + 17'($urandom_range(0, 7));
            prev = END_PTR;
            for (int w = 0; w < nw; w++) begin
                wl[w] = int'($urandom_range(0, 4));
                mem[lfa] = prev[7:0];
                mem[lfa + 17'd1] = prev[15:8];
                mem[lfa + 17'd2] = 8'(wl[w]);
                for (int k = 0; k < wl[w]; k++) begin
                    wn[w][k] = ($urandom_range(0, 1) == 0 ? 8'h61 : 8'h41) + 8'($urandom_range(0, 1));
                    mem[lfa + 17'd3 + 17'(k)] = wn[w][k];
                end
                prev = lfa;
                lfa = lfa + 17'd5 + 17'(wl[w]) + 17'($urandom_range(0, 3));
            end
            ctx = ($urandom_range(0, 9) == 0) ? END_PTR : prev;
            if ($urandom_range(0, 1) == 0) begin
                ln = int'($urandom_range(0, 4));
                for (int k = 0; k < ln; k++)
                    mem[17'h40 + 17'(k)] = ($urandom_range(0, 1) == 0 ? 8'h61 : 8'h41) + 8'($urandom_range(0, 1));
            end else begin
                c0 = int'($urandom_range(0, nw - 1));
                for (int k = 0; k < wl[c0]; k++) mem[17'h40 + 17'(k)] = wn[c0][k];
            end
            model(ctx, 17'h40, mh, ml, mp);
            search_expect($sformatf("rnd%0d", r), ctx, 17'h40, mh, ml, mp, cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/word_finder.md
Name: word_finder

Overview:
- Forth dictionary search engine for eForthChip.
- Takes a null-terminated token in the terminal input buffer (TIB) and walks the linked word list, newest word first.
- Reports whether a word with an identical name exists, and its addresses.
- Reads memory only, through the 8-bit single-port memory bus (mb8_io master modport to spram8_128k); a sibling controller owns writes.

Parameters:
- ASZ, 17, memory address width (128 KB).
- DSZ, 8, memory data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  search enable; a 0->1 start is sampled at posedge.
- aw  in  ASZ  word address: CONTEXT (newest word LFA) while en=0, TIB address at the start edge.
- vw  in  DSZ  memory read data, fed directly from the bus vo.
- bsy  out  1  search in progress.
- hit  out  1  match found (valid when bsy=0 after a search).
- st  out  3  current FSM state (debug).
- ao0  out  ASZ  dictionary pointer; matched word LFA after hit.
- ao1  out  ASZ  TIB pointer during search; matched word PFA after hit.
- mb_if  master  mb8_io  memory bus. Drive we=0 always and the read address from the internal pointer mux; data ports are don't-care.

Behaviour:
- Dictionary entry at LFA:
  - LFA+0/+1: link, 16-bit little-endian, zero-extended to ASZ; 16'hFFFF ends the list.
  - LFA+2: name length n.
  - LFA+3..LFA+2+n: name bytes.
  - PFA = LFA+3+n.
- Memory read latency is 1 cycle: vw in cycle N+1 is the data for the address driven in cycle N.
- Reset, asynchronous: st=IDLE, bsy=0, hit=0, ao0=0, ao1=0, internal context/TIB registers and counters = 0.
- FSM states (st encoding):
  - IDLE(0): bsy=0. If en=0, latch ctx<=aw every cycle. If en=1, latch tib<=aw, clear the TIB length counter, set bsy=1, hit=0, go TLEN.
  - TLEN(1): read TIB bytes sequentially until vw==0. TIB length = bytes before the null, saturating at 255 (scan stops at 255). Then set ao0<=ctx and go LNKL. If ctx==16'hFFFF, go DONE with hit=0.
  - LNKL(2): read LFA+0 and save the low link byte. Go LNKH.
  - LNKH(3): read LFA+1 and save the high link byte. Go LEN.
  - LEN(4): read LFA+2. If length != TIB length, go to next word; otherwise set char index i=0. If n==0, it is a match.
  - CHRD(5): read dictionary byte LFA+3+i into a holding register. Go CHRT.
  - CHRT(6): read TIB+i and compare with the held byte.
    - Mismatch: go to next word.
    - Equal with i==n-1: match.
    - Otherwise i++ and go CHRD.
  - DONE(7): bsy=0, hit and ao0/ao1 held stable while en=1. en=0 returns to IDLE; outputs are held until the next start.
- Next word: ao0<=link. If link==16'hFFFF, go DONE with hit=0; else go LNKL.
- Match: hit=1, ao0=LFA, ao1=PFA, go DONE.
- Comparison is exact byte equality (case-sensitive by default).
- en deasserted during TLEN..CHRT aborts: next cycle IDLE, bsy=0, hit=0.
- rst mid-search: immediate return to reset values.
- Address arithmetic wraps modulo 2^ASZ.
- Only one search per en assertion; a new start requires en to return to 0.

Optional Feature:
- Macro FINDER_NOCASE_EN.
- When defined: before comparison, map ASCII 'a'..'z' to 'A'..'Z' on both bytes, so "ABCD" matches "abcd". Non-letters are unchanged.
- When undefined: exact byte compare; no extra logic.

Test Plan:
- TIB="abcd\0" at 0; dictionary at 0x10 holding abcd, efgh, ijkl, mnop (each PFA = BE EF); aw=LFA of mnop (0x37) with en=0, then en=1 with aw=0 -> hit=1, ao0=0x10, ao1=0x17, bsy falls within 60 cycles.
- Same dictionary, TIB="mnop" -> hit=1 on the first word, ao0=0x37, ao1=0x3E.
- TIB="abce" -> all words visited, link FFFF reached, hit=0, bsy=0, st=7.
- TIB="abc" (length mismatch) and TIB="abcde" -> hit=0; no CHRD state entered for any word.
- Drop en during CHRT, and separately pulse rst mid-search -> IDLE next cycle or immediately, bsy=0, hit=0. A fresh search afterwards succeeds.
- With FINDER_NOCASE_EN: TIB="EFGH" -> hit=1, ao0=0x19. Without the macro: hit=0.
